// File: rtl/lmk61e2_pkg.sv
// lmk61e2_pkg: LMK61E2 register addresses, SWRST value, sequencer FSM states and table entry type
package lmk61e2_pkg;
  localparam logic [7:0] R21 = 8'd21;
  localparam logic [7:0] R22 = 8'd22;
  localparam logic [7:0] R23 = 8'd23;
  localparam logic [7:0] R25 = 8'd25;
  localparam logic [7:0] R26 = 8'd26;
  localparam logic [7:0] R72 = 8'd72;
  localparam logic [7:0] SWRST_VAL = 8'h02;
  typedef enum logic [2:0] {IDLE, WR, RD, NEXT, FAIL, DONE, ERROR} state_t;
  typedef struct packed {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] data;
  } entry_t;
endpackage

// File: rtl/lmk61e2_cfg_table.sv
// lmk61e2_cfg_table: combinational idx -> {rw, addr, data} register table; in idx/out_div/n_div, out ent and last (final valid index)
module lmk61e2_cfg_table import lmk61e2_pkg::*; #(
  parameter logic [7:0] OUT_FMT  = 8'h02,
  parameter bit         SW_RESET = 1'b1
) (
  input  logic [2:0]  idx,
  input  logic [8:0]  out_div,
  input  logic [11:0] n_div,
  output entry_t      ent,
  output logic [2:0]  last
);
  assign last = SW_RESET ? 3'd5 : 3'd4;
  always_comb begin
    ent = {1'b0, R21, OUT_FMT};
    case (idx)
      3'd1:    ent = {1'b0, R22, {7'b0, out_div[8]}};
      3'd2:    ent = {1'b0, R23, out_div[7:0]};
      3'd3:    ent = {1'b0, R25, {4'b0, n_div[11:8]}};
      3'd4:    ent = {1'b0, R26, n_div[7:0]};
      3'd5:    ent = {1'b0, R72, SWRST_VAL};
      default: ent = {1'b0, R21, OUT_FMT};
    endcase
  end
endmodule

// File: rtl/lmk61e2_cfg_seq.sv
// lmk61e2_cfg_seq: LMK61E2 programming sequencer; start/out_div/n_div in, busy/done/error/err_index out, i2c_req/rw/reg/wdata to and i2c_done/nack/rdata from the shared I2C master
module lmk61e2_cfg_seq import lmk61e2_pkg::*; #(
  parameter logic [7:0]  OUT_FMT     = 8'h02,
  parameter bit          VERIFY      = 1'b1,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter bit          SW_RESET    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  out_div,
  input  logic [11:0] n_div,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_index,
  output logic        i2c_req,
  output logic        i2c_rw,
  output logic [7:0]  i2c_reg,
  output logic [7:0]  i2c_wdata,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  input  logic [7:0]  i2c_rdata
);
  state_t      state;
  logic [8:0]  od_q;
  logic [11:0] nd_q;
  logic [2:0]  idx, last, tidx;
  logic [3:0]  retry;
  logic [15:0] tcnt;
  entry_t      ent;
  assign tidx = state == NEXT ? idx + 3'd1 : idx;
  lmk61e2_cfg_table #(.OUT_FMT(OUT_FMT), .SW_RESET(SW_RESET)) u_table (
    .idx(tidx), .out_div(od_q), .n_div(nd_q), .ent(ent), .last(last)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      {busy, done, error, err_index} <= '0;
      {i2c_req, i2c_rw, i2c_reg, i2c_wdata} <= '0;
      {od_q, nd_q, idx, retry, tcnt} <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: if (start) begin
          state <= WR;
          busy <= 1'b1;
          {error, err_index, idx, retry} <= '0;
          od_q <= out_div;
          nd_q <= n_div;
        end
        WR, RD: begin
          if (!i2c_req) begin
            {i2c_req, i2c_rw, i2c_reg, i2c_wdata} <= {1'b1, state == RD, ent.addr, ent.data};
            tcnt <= '0;
          end else if (i2c_done) begin
            i2c_req <= 1'b0;
            if (state == WR) state <= i2c_nack ? FAIL : (VERIFY && idx < 3'd5) ? RD : NEXT;
            else state <= (i2c_nack || i2c_rdata != ent.data) ? FAIL : NEXT;
          end else if (tcnt == 16'(TIMEOUT_CYC - 1)) begin
            i2c_req <= 1'b0;
            state <= FAIL;
          end else tcnt <= tcnt + 16'd1;
        end
        NEXT: if (idx == last) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          idx <= idx + 3'd1;
          retry <= '0;
          state <= WR;
          {i2c_req, i2c_rw, i2c_reg, i2c_wdata} <= {1'b1, ent.rw, ent.addr, ent.data};
          tcnt <= '0;
        end
        FAIL: if (retry < 4'(MAX_RETRY)) begin
          retry <= retry + 4'd1;
          state <= WR;
          {i2c_req, i2c_rw, i2c_reg, i2c_wdata} <= {1'b1, ent.rw, ent.addr, ent.data};
          tcnt <= '0;
        end else begin
          state <= ERROR;
          busy <= 1'b0;
          error <= 1'b1;
          err_index <= idx;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/lmk61e2_cfg_seq.md
Name: lmk61e2_cfg_seq

Overview:
- Sequencer that programs the LMK61E2 clock synthesiser over the shared I2C master at power-up or on request.
- Walks a fixed register table whose data fields come from parameters and run-time inputs: output format, 9-bit output divider, 12-bit PLL N divider.
- Optionally reads back each register after writing it and compares the value, with a bounded retry count.
- Sits between the board control logic and the generic I2C master; reports busy, done and error status.

Parameters:
- OUT_FMT, 8'h02, value written to R21 DIFFCTL (8'h02 = LVDS).
- VERIFY, 1, 1 = read back and compare every written register; 0 = write only.
- MAX_RETRY, 3, extra attempts per entry after a NACK or mismatch (0..15).
- TIMEOUT_CYC, 65535, clock cycles to wait for i2c_done before the attempt counts as failed.
- SW_RESET, 1, 1 = append a write of 8'h02 to R72 SWRST as the last entry; 0 = omit it.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a sequence when idle
- out_div  in  9  output divider, sampled on the accepted start
- n_div  in  12  PLL integer N, sampled on the accepted start
- busy  out  1  high from the accepted start until done or error
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky; cleared by the next accepted start
- err_index  out  3  table index that failed
- i2c_req  out  1  transaction request to the I2C master
- i2c_rw  out  1  0 = write, 1 = read
- i2c_reg  out  8  register address
- i2c_wdata  out  8  write data
- i2c_done  in  1  one-cycle pulse; transaction finished
- i2c_nack  in  1  valid with i2c_done; slave NACKed
- i2c_rdata  in  8  valid with i2c_done on reads

Behaviour:
- Reset: all outputs 0; FSM in IDLE; latched dividers, index, retry and timeout counters all 0. A reset mid-sequence aborts at once with no further requests. The I2C master is reset from the same source.
- Table, indices 0..5:
  - 0: R21 = OUT_FMT
  - 1: R22 = {7'b0, out_div[8]}
  - 2: R23 = out_div[7:0]
  - 3: R25 = {4'b0, n_div[11:8]}
  - 4: R26 = n_div[7:0]
  - 5: R72 = 8'h02, only when SW_RESET = 1
  - Last index = 4 or 5 according to SW_RESET. Entry 5 is never verified, because SWRST self-clears.
- Start handling: start is accepted only in IDLE, DONE or ERROR. It latches out_div and n_div, clears error and err_index, and sets index and retry to 0. A start while busy is ignored.
- Handshake: i2c_req is asserted and held, with i2c_rw, i2c_reg and i2c_wdata stable, until the cycle i2c_done is seen. i2c_req drops in the cycle after i2c_done. At most one request is outstanding.
- States:
  - IDLE: wait for start.
  - WR: i2c_req with rw = 0. On done with nack go to FAIL; on done without nack go to RD if VERIFY and index < 5, otherwise NEXT.
  - RD: i2c_req with rw = 1, same address. On done go to FAIL if nack or i2c_rdata differs from the table data, otherwise NEXT.
  - NEXT: if index = last go to DONE, otherwise index+1, retry = 0, go to WR.
  - FAIL: if retry < MAX_RETRY then retry+1 and go back to WR for the same index; otherwise go to ERROR.
  - DONE: done pulses one cycle; stay until start.
  - ERROR: error = 1, err_index = index; stay until start.
- Timeout: a counter runs in WR and RD and clears on each new request. Reaching TIMEOUT_CYC counts as a failure: drop i2c_req, go to FAIL. An i2c_done arriving in the same cycle as the timeout wins.
- busy = 1 in every state except IDLE, DONE and ERROR.
- Latency: request-to-request gap is 2 cycles after i2c_done. With a zero-latency master responding in 1 cycle, a full VERIFY run completes in a fixed number of cycles for the bench to check.

Decomposition:
- Shared package lmk61e2_pkg: register address constants (R21, R22, R23, R25, R26, R72), the SWRST value 8'h02, the FSM state enum, and the table entry struct {rw, addr, data}.
- One sub-module: lmk61e2_cfg_table, a combinational index -> entry lookup driven by out_div, n_div, OUT_FMT and SW_RESET.

Test Plan:
- Basic write run: start with out_div = 9'h105, n_div = 12'h0A3, VERIFY = 1, master echoing written data -> writes R21 = 02, R22 = 01, R23 = 05, R25 = 00, R26 = A3, R72 = 02, each write followed by a matching read, done pulses once, error stays 0.
- NACK retry then pass: NACK the first write of R23 twice, MAX_RETRY = 3 -> R23 write issued 3 times, the sequence then completes with done.
- Verify mismatch to error: readback of R25 returns 8'h01 on every attempt -> 4 write/read pairs, then error = 1, err_index = 3, busy = 0, no R26 request.
- Timeout: master never asserts i2c_done for R21 with TIMEOUT_CYC = 16 -> i2c_req drops after 16 cycles and is retried; error with err_index = 0 after MAX_RETRY + 1 attempts.
- Start while busy is ignored and inputs are latched: pulse start mid-sequence with a different out_div -> no restart, and R23 data equals the out_div latched at the accepted start.
- Reset mid-transaction, with VERIFY = 0 and SW_RESET = 0: assert reset while i2c_req is high -> next cycle all outputs are 0; a new start runs exactly 5 writes with no reads and pulses done.
